// File: rtl/rand_share_arbiter_pkg.sv
// Shared synth definitions: default LFSR seed, arbiter state encoding and the
// 32-bit Galois LFSR step used by both the arbiter and the noise datapath.
package rand_share_arbiter_pkg;

    localparam logic [31:0] LFSR_SEED_DEFAULT = 32'hA61BE539;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_STEP  = 2'd2
    } arb_state_t;

    function automatic logic [31:0] lfsr_next(input logic [31:0] v);
        logic b;
        b = v[0];
        return {b, v[31], v[30] ^ b, v[29] ^ b, v[28], v[27] ^ b, v[26:1]};
    endfunction

endpackage

// File: rtl/rand_share_arbiter_rr_pick.sv
// Combinational round-robin search: first set request at or above i_ptr,
// wrapping from N_REQ-1 back to 0.
module rand_share_arbiter_rr_pick #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic             o_hit,
    output logic [IDX_W-1:0] o_idx
);

    logic [IDX_W-1:0] w_cand [N_REQ];
    logic [N_REQ-1:0] w_cand_req;

    // w_cand[gi] is the requester visited gi steps after the pointer.
    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_cand
            logic [IDX_W:0] w_sum;
            assign w_sum = {1'b0, i_ptr} + (IDX_W+1)'(gi);
            assign w_cand[gi] = (w_sum >= (IDX_W+1)'(N_REQ))
                              ? IDX_W'(w_sum - (IDX_W+1)'(N_REQ))
                              : w_sum[IDX_W-1:0];
            assign w_cand_req[gi] = i_req[w_cand[gi]];
        end
    endgenerate

    always_comb begin
        o_hit = |i_req;
        o_idx = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (w_cand_req[k]) begin
                o_idx = w_cand[k];
            end
        end
    end

endmodule

// File: rtl/rand_share_arbiter.sv
// Round-robin req/ack arbiter sharing one 32-bit Galois LFSR; each grant steps
// the LFSR once and hands the upper 16 bits to the granted requester.
module rand_share_arbiter
    import rand_share_arbiter_pkg::*;
#(
    parameter int          N_REQ        = 4,
    parameter logic [31:0] SEED_DEFAULT = LFSR_SEED_DEFAULT
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_locked,
    input  logic [N_REQ-1:0] i_req,
    input  logic             i_seed_load,
    input  logic [31:0]      i_seed,
    output logic [N_REQ-1:0] o_ack,
    output logic [15:0]      o_rand,
    output logic             o_busy
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    arb_state_t       r_state;
    logic [31:0]      r_lfsr;
    logic [IDX_W-1:0] r_rr_ptr;
    logic [IDX_W-1:0] r_gnt_idx;
    logic [N_REQ-1:0] r_ack;
    logic [15:0]      r_rand;
    logic             r_busy;

    logic             w_hit;
    logic [IDX_W-1:0] w_idx;
    logic [31:0]      w_lfsr_step;
    logic [31:0]      w_seed_val;
    logic [N_REQ-1:0] w_gnt_onehot;
    logic [IDX_W-1:0] w_ptr_next;

    rand_share_arbiter_rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .i_req (i_req),
        .i_ptr (r_rr_ptr),
        .o_hit (w_hit),
        .o_idx (w_idx)
    );

    // An all-zero seed would lock the LFSR at zero forever.
    assign w_seed_val   = (i_seed == 32'h0) ? SEED_DEFAULT : i_seed;
    assign w_lfsr_step  = lfsr_next(r_lfsr);
    assign w_gnt_onehot = N_REQ'(1) << r_gnt_idx;
    assign w_ptr_next   = (r_gnt_idx == IDX_W'(N_REQ - 1)) ? '0 : r_gnt_idx + 1'b1;

    // The step, ACK, RAND and pointer update all land on the GRANT->STEP edge,
    // so ACK is visible for the whole STEP cycle and the requester can drop REQ
    // on the edge that leaves STEP, before IDLE samples it again.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state   <= ST_IDLE;
            r_lfsr    <= SEED_DEFAULT;
            r_rr_ptr  <= '0;
            r_gnt_idx <= '0;
            r_ack     <= '0;
            r_rand    <= 16'h8000;
            r_busy    <= 1'b0;
        end else begin
            r_ack <= '0;
            if (i_seed_load) begin
                r_lfsr <= w_seed_val;
            end
            case (r_state)
                ST_IDLE: begin
                    if (i_locked && w_hit) begin
                        r_gnt_idx <= w_idx;
                        r_state   <= ST_GRANT;
                        r_busy    <= 1'b1;
                    end
                end
                ST_GRANT: begin
                    if (!i_locked) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else if (!i_seed_load) begin
                        // A coincident reseed holds us in GRANT so the step uses the new seed.
                        r_lfsr   <= w_lfsr_step;
                        r_rand   <= w_lfsr_step[31:16];
                        r_ack    <= w_gnt_onehot;
                        r_rr_ptr <= w_ptr_next;
                        r_state  <= ST_STEP;
                    end
                end
                ST_STEP: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_ack  = r_ack;
    assign o_rand = r_rand;
    assign o_busy = r_busy;

endmodule
